pipe_control_unit: RTL and testbench

- Next-generation main control for the pipelined MIPS datapath: decodes the ID-stage opcode into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers.
- Adds load-use hazard detection with stall and bubble insertion, and IF/ID flush on taken branches and jumps.
- Destination-register selection (rt/rd/r31) is folded in; register-index and ALUOp widths are parametrised.
- Sits between the IF/ID register and the datapath stage registers.

---
 rtl/pipe_control_unit_if.sv | 45 ++++
 rtl/pipe_control_unit.sv | 141 ++++++++++++++
 tb/tb_pipe_control_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_control_unit_if.sv
// ID-stage inputs and pipelined control outputs of the MIPS main control unit.
// The slave modport is the control unit; master is the IF/ID + datapath side.
interface pipe_control_unit_if #(
   parameter int unsigned OPW    = 6,
   parameter int unsigned REGW   = 5,
   parameter int unsigned ALUOPW = 4
);
   logic              id_valid;
   logic [OPW-1:0]    id_opcode;
   logic [REGW-1:0]   id_rs;
   logic [REGW-1:0]   id_rt;
   logic [REGW-1:0]   id_rd;
   logic              ex_branch_taken;
   logic              stall;
   logic              flush;
   logic [1:0]        id_jump;
   logic              id_illegal;
   logic              ex_alusrc;
   logic [ALUOPW-1:0] ex_aluop;
   logic              ex_branch;
   logic [REGW-1:0]   ex_dst;
   logic [1:0]        ex_memread;
   logic [1:0]        ex_memwrite;
   logic [1:0]        mem_memread;
   logic [1:0]        mem_memwrite;
   logic              mem_regwrite;
   logic [REGW-1:0]   mem_dst;
   logic              wb_regwrite;
   logic              wb_memtoreg;
   logic [REGW-1:0]   wb_dst;

   modport master (
      output id_valid, id_opcode, id_rs, id_rt, id_rd, ex_branch_taken,
      input  stall, flush, id_jump, id_illegal, ex_alusrc, ex_aluop, ex_branch, ex_dst,
      input  ex_memread, ex_memwrite, mem_memread, mem_memwrite, mem_regwrite, mem_dst,
      input  wb_regwrite, wb_memtoreg, wb_dst
   );

   modport slave (
      input  id_valid, id_opcode, id_rs, id_rt, id_rd, ex_branch_taken,
      output stall, flush, id_jump, id_illegal, ex_alusrc, ex_aluop, ex_branch, ex_dst,
      output ex_memread, ex_memwrite, mem_memread, mem_memwrite, mem_regwrite, mem_dst,
      output wb_regwrite, wb_memtoreg, wb_dst
   );
endinterface

// File: rtl/pipe_control_unit.sv
// Pipelined MIPS main control: ID decode, load-use stall, branch/jump flush,
// and the ID/EX, EX/MEM, MEM/WB control registers.
module pipe_control_unit #(
   parameter int unsigned OPW      = 6,
   parameter int unsigned REGW     = 5,
   parameter int unsigned ALUOPW   = 4,
   parameter int unsigned LINK_REG = 31
) (
   input logic               clk,
   input logic               reset,
   pipe_control_unit_if.slave bus
);
   typedef struct packed {
      logic [ALUOPW-1:0] aluop;
      logic              alusrc;
      logic              branch;
      logic [1:0]        memread;
      logic [1:0]        memwrite;
      logic              memtoreg;
      logic              regwrite;
      logic [REGW-1:0]   dst;
   } ex_ctrl_t;

   typedef struct packed {
      logic [1:0]      memread;
      logic [1:0]      memwrite;
      logic            memtoreg;
      logic            regwrite;
      logic [REGW-1:0] dst;
   } mem_ctrl_t;

   typedef struct packed {
      logic            memtoreg;
      logic            regwrite;
      logic [REGW-1:0] dst;
   } wb_ctrl_t;

   ex_ctrl_t  dec, ex_d, ex_q;
   mem_ctrl_t mem_d, mem_q;
   wb_ctrl_t  wb_d, wb_q;
   logic [1:0] jump;
   logic illegal, use_rs, use_rt, branch_taken, load_use, stall;

   always_comb begin
      dec     = '0;
      jump    = 2'b00;
      illegal = 1'b0;
      use_rs  = 1'b1;
      use_rt  = 1'b0;
      case (bus.id_opcode)
         6'b000000: begin dec.regwrite = 1'b1; dec.dst = bus.id_rd; use_rt = 1'b1; end
         6'b100011, 6'b100000, 6'b100001: begin
            dec.aluop    = ALUOPW'(4'b0100);
            dec.alusrc   = 1'b1;
            dec.memtoreg = 1'b1;
            dec.regwrite = 1'b1;
            dec.dst      = bus.id_rt;
            dec.memread  = (bus.id_opcode == 6'b100011) ? 2'b01 :
                           (bus.id_opcode == 6'b100000) ? 2'b10 : 2'b11;
         end
         6'b101011, 6'b101000, 6'b101001: begin
            dec.aluop    = ALUOPW'(4'b0100);
            dec.alusrc   = 1'b1;
            use_rt       = 1'b1;
            dec.memwrite = (bus.id_opcode == 6'b101011) ? 2'b01 :
                           (bus.id_opcode == 6'b101000) ? 2'b10 : 2'b11;
         end
         6'b001000, 6'b001010, 6'b001111, 6'b001100, 6'b001101: begin
            dec.alusrc   = 1'b1;
            dec.regwrite = 1'b1;
            dec.dst      = bus.id_rt;
            case (bus.id_opcode)
               6'b001010: dec.aluop = ALUOPW'(4'b0010);
               6'b001111: begin dec.aluop = ALUOPW'(4'b0001); use_rs = 1'b0; end
               6'b001100: dec.aluop = ALUOPW'(4'b1100);
               6'b001101: dec.aluop = ALUOPW'(4'b1110);
               default:   dec.aluop = ALUOPW'(4'b0100);
            endcase
         end
         6'b000100: begin dec.aluop = ALUOPW'(4'b0101); dec.branch = 1'b1; use_rt = 1'b1; end
         6'b000101: begin dec.aluop = ALUOPW'(4'b0111); dec.branch = 1'b1; use_rt = 1'b1; end
         6'b000111: begin dec.aluop = ALUOPW'(4'b1111); dec.branch = 1'b1; end
         6'b000010: begin jump = 2'b01; use_rs = 1'b0; end
         6'b000011: begin
            jump         = 2'b10;
            use_rs       = 1'b0;
            dec.regwrite = 1'b1;
            dec.dst      = REGW'(LINK_REG);
         end
         6'b011000: jump = 2'b11;
         default:   illegal = 1'b1;
      endcase
      if (!bus.id_valid) begin
         dec     = '0;
         jump    = 2'b00;
         illegal = 1'b0;
      end
   end

   // A taken branch squashes ID outright, so it overrides any load-use stall.
   always_comb begin
      branch_taken = ex_q.branch & bus.ex_branch_taken;
      load_use     = bus.id_valid & (|ex_q.memread) & (|ex_q.dst) &
                     ((use_rs & (ex_q.dst == bus.id_rs)) | (use_rt & (ex_q.dst == bus.id_rt)));
      stall        = load_use & ~branch_taken;
      ex_d         = (stall | branch_taken) ? '0 : dec;
      mem_d        = '{memread: ex_q.memread, memwrite: ex_q.memwrite,
                       memtoreg: ex_q.memtoreg, regwrite: ex_q.regwrite, dst: ex_q.dst};
      wb_d         = '{memtoreg: mem_q.memtoreg, regwrite: mem_q.regwrite, dst: mem_q.dst};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   assign bus.stall        = stall;
   assign bus.flush        = branch_taken | ((|jump) & ~stall);
   assign bus.id_jump      = jump;
   assign bus.id_illegal   = illegal;
   assign bus.ex_alusrc    = ex_q.alusrc;
   assign bus.ex_aluop     = ex_q.aluop;
   assign bus.ex_branch    = ex_q.branch;
   assign bus.ex_dst       = ex_q.dst;
   assign bus.ex_memread   = ex_q.memread;
   assign bus.ex_memwrite  = ex_q.memwrite;
   assign bus.mem_memread  = mem_q.memread;
   assign bus.mem_memwrite = mem_q.memwrite;
   assign bus.mem_regwrite = mem_q.regwrite;
   assign bus.mem_dst      = mem_q.dst;
   assign bus.wb_regwrite  = wb_q.regwrite;
   assign bus.wb_memtoreg  = wb_q.memtoreg;
   assign bus.wb_dst       = wb_q.dst;
endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: table-driven reference model checked every
// cycle, plus hand-computed literal expectations at the interesting points.
module tb_pipe_control_unit;
   localparam int OP_R = 'h00, OP_LW = 'h23, OP_SH = 'h29, OP_ADDI = 'h08, OP_BEQ = 'h04;
   localparam int OP_JAL = 'h03, OP_JR = 'h18, OP_BAD = 'h3f;

   typedef struct {
      int op; int aluop; int alusrc; int mr; int mw; int m2r; int rw; int br;
      int dsel; int jmp; int srs; int srt;
   } row_t;
   typedef struct { int aluop; int alusrc; int br; int dst; int mr; int mw; int m2r; int rw; } mb_t;

   // dsel: 0 none, 1 rt, 2 rd, 3 link register
   row_t tbl [18] = '{
      '{'h00, 0, 0, 0, 0, 0, 1, 0, 2, 0, 1, 1}, '{'h23, 4, 1, 1, 0, 1, 1, 0, 1, 0, 1, 0},
      '{'h20, 4, 1, 2, 0, 1, 1, 0, 1, 0, 1, 0}, '{'h21, 4, 1, 3, 0, 1, 1, 0, 1, 0, 1, 0},
      '{'h2b, 4, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1}, '{'h28, 4, 1, 0, 2, 0, 0, 0, 0, 0, 1, 1},
      '{'h29, 4, 1, 0, 3, 0, 0, 0, 0, 0, 1, 1}, '{'h08, 4, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0},
      '{'h0a, 2, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0}, '{'h0f, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0},
      '{'h0c, 12, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0}, '{'h0d, 14, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0},
      '{'h04, 5, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1}, '{'h05, 7, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1},
      '{'h07, 15, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0}, '{'h02, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0},
      '{'h03, 0, 0, 0, 0, 0, 1, 0, 3, 2, 0, 0}, '{'h18, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0}
   };

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipe_control_unit_if #(.OPW(6), .REGW(5), .ALUOPW(4)) bus ();
   pipe_control_unit #(.OPW(6), .REGW(5), .ALUOPW(4), .LINK_REG(31)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int checks = 0, failures = 0;
   int cv, cop, crs, crt, crd, ctk;
   mb_t m_ex, m_mem, m_wb, n_ex, zero_mb;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic lookup(input int op, output row_t r, output bit found);
      found = 1'b0;
      r = tbl[0];
      foreach (tbl[i]) if (tbl[i].op == op) begin r = tbl[i]; found = 1'b1; end
   endtask

   task automatic drive(input int v, input int op, input int rs, input int rt, input int rd,
                        input int tk);
      cv = v; cop = op; crs = rs; crt = rt; crd = rd; ctk = tk;
      bus.id_valid = (v != 0);
      bus.id_opcode = op[5:0];
      bus.id_rs = rs[4:0];
      bus.id_rt = rt[4:0];
      bus.id_rd = rd[4:0];
      bus.ex_branch_taken = (tk != 0);
      #2;
   endtask

   task automatic check_regs_zero(input string tag);
      chk({tag, "_ex_aluop"}, int'(bus.ex_aluop), 0);
      chk({tag, "_ex_memread"}, int'(bus.ex_memread), 0);
      chk({tag, "_ex_dst"}, int'(bus.ex_dst), 0);
      chk({tag, "_mem_regwrite"}, int'(bus.mem_regwrite), 0);
      chk({tag, "_wb_regwrite"}, int'(bus.wb_regwrite), 0);
      chk({tag, "_wb_dst"}, int'(bus.wb_dst), 0);
   endtask

   // Model check of every output for the currently driven ID inputs, then advance.
   task automatic tick();
      row_t r;
      bit f;
      int taken, hz, e_stall, e_jmp, e_flush, srs, srt;
      lookup(cop, r, f);
      srs = f ? r.srs : 1;
      srt = f ? r.srt : 0;
      taken = (m_ex.br != 0 && ctk != 0) ? 1 : 0;
      hz = (cv != 0 && m_ex.mr != 0 && m_ex.dst != 0 &&
            ((srs != 0 && m_ex.dst == crs) || (srt != 0 && m_ex.dst == crt))) ? 1 : 0;
      e_stall = (hz != 0 && taken == 0) ? 1 : 0;
      e_jmp = (cv != 0 && f) ? r.jmp : 0;
      e_flush = (taken != 0 || (e_jmp != 0 && e_stall == 0)) ? 1 : 0;
      chk("stall", int'(bus.stall), e_stall);
      chk("flush", int'(bus.flush), e_flush);
      chk("id_jump", int'(bus.id_jump), e_jmp);
      chk("id_illegal", int'(bus.id_illegal), (cv != 0 && !f) ? 1 : 0);
      chk("ex_alusrc", int'(bus.ex_alusrc), m_ex.alusrc);
      chk("ex_aluop", int'(bus.ex_aluop), m_ex.aluop);
      chk("ex_branch", int'(bus.ex_branch), m_ex.br);
      chk("ex_dst", int'(bus.ex_dst), m_ex.dst);
      chk("ex_memread", int'(bus.ex_memread), m_ex.mr);
      chk("ex_memwrite", int'(bus.ex_memwrite), m_ex.mw);
      chk("mem_memread", int'(bus.mem_memread), m_mem.mr);
      chk("mem_memwrite", int'(bus.mem_memwrite), m_mem.mw);
      chk("mem_regwrite", int'(bus.mem_regwrite), m_mem.rw);
      chk("mem_dst", int'(bus.mem_dst), m_mem.dst);
      chk("wb_regwrite", int'(bus.wb_regwrite), m_wb.rw);
      chk("wb_memtoreg", int'(bus.wb_memtoreg), m_wb.m2r);
      chk("wb_dst", int'(bus.wb_dst), m_wb.dst);
      n_ex = zero_mb;
      if (cv != 0 && f && e_stall == 0 && taken == 0) begin
         n_ex = '{r.aluop, r.alusrc, r.br, 0, r.mr, r.mw, r.m2r, r.rw};
         n_ex.dst = (r.dsel == 1) ? crt : (r.dsel == 2) ? crd : (r.dsel == 3) ? 31 : 0;
      end
      m_wb = m_mem;
      m_mem = m_ex;
      m_ex = n_ex;
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      drive(0, 0, 0, 0, 0, 0);
      tick();
   endtask

   initial begin
      zero_mb = '{0, 0, 0, 0, 0, 0, 0, 0};
      m_ex = zero_mb; m_mem = zero_mb; m_wb = zero_mb;
      reset = 1'b1;
      bus.id_valid = 1'b0; bus.id_opcode = '0; bus.id_rs = '0; bus.id_rt = '0;
      bus.id_rd = '0; bus.ex_branch_taken = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check_regs_zero("reset");

      // lw $8 then addi rs=9: no stall, load reaches WB after three edges
      drive(1, OP_LW, 1, 8, 0, 0);
      chk("lw_stall", int'(bus.stall), 0);
      tick();
      drive(1, OP_ADDI, 9, 3, 0, 0);
      chk("lw_ex_memread", int'(bus.ex_memread), 1);
      chk("lw_ex_dst", int'(bus.ex_dst), 8);
      chk("addi_stall", int'(bus.stall), 0);
      tick();
      nop();
      drive(0, 0, 0, 0, 0, 0);
      chk("lw_wb_regwrite", int'(bus.wb_regwrite), 1);
      chk("lw_wb_memtoreg", int'(bus.wb_memtoreg), 1);
      chk("lw_wb_dst", int'(bus.wb_dst), 8);
      tick();

      // load-use: one stall cycle, then a bubble in EX
      drive(1, OP_LW, 1, 8, 0, 0); tick();
      drive(1, OP_R, 8, 10, 11, 0);
      chk("lu_stall", int'(bus.stall), 1);
      tick();
      drive(1, OP_R, 8, 10, 11, 0);
      chk("lu_stall_clear", int'(bus.stall), 0);
      chk("lu_bubble_memread", int'(bus.ex_memread), 0);
      chk("lu_bubble_dst", int'(bus.ex_dst), 0);
      tick();
      drive(1, OP_LW, 1, 8, 0, 0); tick();
      drive(1, OP_R, 9, 10, 8, 0);
      chk("rd_only_stall", int'(bus.stall), 0);
      tick();
      drive(1, OP_LW, 1, 0, 0, 0); tick();
      drive(1, OP_R, 0, 0, 5, 0);
      chk("dst0_stall", int'(bus.stall), 0);
      tick();

      // load in EX with a jump using it in ID: flush deferred until stall clears
      drive(1, OP_LW, 1, 8, 0, 0); tick();
      drive(1, OP_JR, 8, 0, 0, 0);
      chk("jr_stall", int'(bus.stall), 1);
      chk("jr_flush_held", int'(bus.flush), 0);
      tick();
      drive(1, OP_JR, 8, 0, 0, 0);
      chk("jr_flush", int'(bus.flush), 1);
      tick();

      // taken branch flushes and bubbles; not-taken does not
      drive(1, OP_BEQ, 1, 2, 0, 0); tick();
      drive(1, OP_LW, 3, 5, 0, 1);
      chk("br_flush", int'(bus.flush), 1);
      chk("br_stall", int'(bus.stall), 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk("br_bubble_memread", int'(bus.ex_memread), 0);
      chk("br_bubble_alusrc", int'(bus.ex_alusrc), 0);
      tick();
      drive(1, OP_BEQ, 1, 2, 0, 0); tick();
      drive(1, OP_ADDI, 3, 6, 0, 0);
      chk("br_nt_flush", int'(bus.flush), 0);
      tick();

      // jal: flush one cycle, link write reaches WB three edges later
      drive(1, OP_JAL, 0, 0, 0, 0);
      chk("jal_jump", int'(bus.id_jump), 2);
      chk("jal_flush", int'(bus.flush), 1);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk("jal_flush_once", int'(bus.flush), 0);
      tick();
      nop();
      drive(0, 0, 0, 0, 0, 0);
      chk("jal_wb_regwrite", int'(bus.wb_regwrite), 1);
      chk("jal_wb_dst", int'(bus.wb_dst), 31);
      tick();

      // sh and an illegal opcode
      drive(1, OP_SH, 1, 2, 0, 0); tick();
      drive(1, OP_BAD, 1, 2, 3, 0);
      chk("bad_illegal", int'(bus.id_illegal), 1);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk("sh_mem_memwrite", int'(bus.mem_memwrite), 3);
      chk("sh_mem_regwrite", int'(bus.mem_regwrite), 0);
      tick();
      nop();
      drive(0, 0, 0, 0, 0, 0);
      chk("bad_wb_regwrite", int'(bus.wb_regwrite), 0);
      chk("bad_wb_dst", int'(bus.wb_dst), 0);
      tick();

      // every table opcode once, model-checked
      foreach (tbl[i]) begin
         drive(1, tbl[i].op, 3, 4, 5, 0);
         tick();
      end
      repeat (3) nop();

      // asynchronous reset while a stall is pending
      drive(1, OP_LW, 1, 8, 0, 0); tick();
      drive(1, OP_R, 8, 10, 11, 0);
      chk("mid_stall", int'(bus.stall), 1);
      reset = 1'b1;
      #1;
      check_regs_zero("async");
      chk("async_stall", int'(bus.stall), 0);
      m_ex = zero_mb; m_mem = zero_mb; m_wb = zero_mb;
      #1 reset = 1'b0;
      tick();
      drive(1, OP_ADDI, 2, 7, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0);
      chk("post_rst_aluop", int'(bus.ex_aluop), 4);
      chk("post_rst_dst", int'(bus.ex_dst), 7);
      tick();
      repeat (3) nop();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
